// File: rtl/sync_evt_stamp_pkg.sv
// Shared defaults and helpers for the bclk-domain event timestamping blocks.
// Imported by sync_evt_fifo and sync_evt_stamp.
package sync_evt_stamp_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_evt_fifo.sv
// First-word-fall-through timestamp buffer: head entry is visible on dout
// whenever the buffer is non-empty. DEPTH must be a power of two.
module sync_evt_fifo
    import sync_evt_stamp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = TS_W_DEF
) (
    input  logic                   bclk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int              AW       = clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign pop_ok  = pop & ~empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage is reset too, so the head output reads 0 out of reset instead of X.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // NOTE: non-blocking updates, so every flop samples the pre-edge values of the others.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/sync_evt_stamp.sv
// Turns the synchronised level into one event per rising edge, stamps it with a
// free-running bclk counter and queues the stamps for a valid/ready consumer.
module sync_evt_stamp
    import sync_evt_stamp_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   bclk,
    input  logic                   rst,
    input  logic                   sync_in,
    input  logic                   clr,
    output logic                   evt_pulse,
    output logic                   evt_valid,
    output logic [TS_W-1:0]        evt_ts,
    input  logic                   evt_ready,
    output logic [CNT_W-1:0]       evt_cnt,
    output logic                   ovf,
    output logic [clog2(DEPTH):0]  level
);

    logic [TS_W-1:0]  ts_q,        ts_d;
    logic             sync_dly_q,  sync_dly_d;
    logic             armed_q,     armed_d;
    logic             evt_pulse_q, evt_pulse_d;
    logic [CNT_W-1:0] evt_cnt_q,   evt_cnt_d;
    logic             ovf_q,       ovf_d;
    logic             rise;
    logic             evt;
    logic             fifo_full;
    logic             fifo_empty;

    // The first edge after reset only primes sync_dly, so a level already high
    // at release is not mistaken for a fresh 0->1.
    assign rise = sync_in & ~sync_dly_q & armed_q;
    assign evt  = rise & ~clr;

    always_comb begin
        ts_d        = ts_q + TS_W'(1);
        sync_dly_d  = sync_in;
        armed_d     = 1'b1;
        evt_pulse_d = evt;
        evt_cnt_d   = evt_cnt_q;
        ovf_d       = ovf_q;
        if (clr) begin
            evt_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (evt && (evt_cnt_q != '1)) begin
                evt_cnt_d = evt_cnt_q + CNT_W'(1);
            end
            // A full buffer only drops the event when the head is not leaving too.
            if (evt && fifo_full && !evt_ready) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            ts_q        <= '0;
            sync_dly_q  <= 1'b0;
            armed_q     <= 1'b0;
            evt_pulse_q <= 1'b0;
            evt_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            sync_dly_q  <= sync_dly_d;
            armed_q     <= armed_d;
            evt_pulse_q <= evt_pulse_d;
            evt_cnt_q   <= evt_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_evt_fifo #(
        .DEPTH (DEPTH),
        .DW    (TS_W)
    ) u_fifo (
        .bclk  (bclk),
        .rst   (rst),
        .push  (evt),
        .din   (ts_q),
        .pop   (evt_ready),
        .flush (clr),
        .dout  (evt_ts),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_pulse = evt_pulse_q;
    assign evt_cnt   = evt_cnt_q;
    assign ovf       = ovf_q;

endmodule
